// File: rtl/uart_tx_parity_if.sv
// Byte-in / serial-out bundle between a data source and the parity UART transmitter.
// The source uses the master modport; the transmitter uses the slave modport.
interface uart_tx_parity_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_Tx_Parity;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Parity
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Parity
  );
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, 8 data bits LSB-first, parity, 1 or 2 stop bits.
// A one-entry holding register queues the next byte so frames run back-to-back.
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_tx_parity_if.slave  tx
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic             hold_vld_q, hold_vld_d;
  logic             parity_q, parity_d;
  logic             ready_q, ready_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             load, accept, bit_end;

  function automatic logic calc_parity(input logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_byte_d = hold_byte_q;
    parity_d    = parity_q;
    load        = 1'b0;
    accept      = tx.i_Tx_DV & ready_q;
    bit_end     = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (hold_vld_q) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = PARITY;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            if (hold_vld_q) load    = 1'b1;
            else            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Draining the holding register restarts the frame with no idle cycle.
    if (load) begin
      state_d  = START;
      cnt_d    = '0;
      idx_d    = '0;
      shift_d  = hold_byte_q;
      parity_d = calc_parity(hold_byte_q);
    end

    hold_vld_d = (hold_vld_q & ~load) | accept;
    if (accept) hold_byte_d = tx.i_Tx_Byte;
    ready_d = ~hold_vld_d;

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = parity_d;
      default: serial_d = 1'b1;
    endcase

    // Outputs are registered, so they are decoded from the next-state values.
    active_d = (state_d != IDLE);
    done_d   = (state_d == STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
  end

  always_ff @(posedge i_Clock) begin
    shift_q     <= shift_d;
    hold_byte_q <= hold_byte_d;
    if (i_Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_vld_q <= 1'b0;
      parity_q   <= 1'b0;
      ready_q    <= 1'b1;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hold_vld_q <= hold_vld_d;
      parity_q   <= parity_d;
      ready_q    <= ready_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Tx_Parity = parity_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: three parameterisations (even/1 stop,
// odd/1 stop, even/2 stop) driven in sequence, plus a loopback receiver model.
module tb_uart_tx_parity;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv  [3];
  logic [7:0] byt [3];
  int         sel;

  always #5 clk = ~clk;

  uart_tx_parity_if if_e ();
  uart_tx_parity_if if_o ();
  uart_tx_parity_if if_s ();

  assign if_e.i_Tx_DV   = dv[0];
  assign if_e.i_Tx_Byte = byt[0];
  assign if_o.i_Tx_DV   = dv[1];
  assign if_o.i_Tx_Byte = byt[1];
  assign if_s.i_Tx_DV   = dv[2];
  assign if_s.i_Tx_Byte = byt[2];

  uart_tx_parity #(.CLKS_PER_BIT(87), .PARITY_ODD(0), .STOP_BITS(1)) u_e (
    .i_Clock(clk), .i_Reset(rst), .tx(if_e));
  uart_tx_parity #(.CLKS_PER_BIT(87), .PARITY_ODD(1), .STOP_BITS(1)) u_o (
    .i_Clock(clk), .i_Reset(rst), .tx(if_o));
  uart_tx_parity #(.CLKS_PER_BIT(87), .PARITY_ODD(0), .STOP_BITS(2)) u_s (
    .i_Clock(clk), .i_Reset(rst), .tx(if_s));

  logic m_ser, m_rdy, m_act, m_done, m_par;
  always_comb begin
    case (sel)
      1: begin
        m_ser = if_o.o_Tx_Serial; m_rdy = if_o.o_Tx_Ready; m_act = if_o.o_Tx_Active;
        m_done = if_o.o_Tx_Done;  m_par = if_o.o_Tx_Parity;
      end
      2: begin
        m_ser = if_s.o_Tx_Serial; m_rdy = if_s.o_Tx_Ready; m_act = if_s.o_Tx_Active;
        m_done = if_s.o_Tx_Done;  m_par = if_s.o_Tx_Parity;
      end
      default: begin
        m_ser = if_e.o_Tx_Serial; m_rdy = if_e.o_Tx_Ready; m_act = if_e.o_Tx_Active;
        m_done = if_e.o_Tx_Done;  m_par = if_e.o_Tx_Parity;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;

  logic ser_log  [2400];
  logic rdy_log  [2400];
  logic act_log  [2400];
  logic done_log [2400];
  logic par_log  [2400];

  int         sch_off  [2];
  logic [7:0] sch_byte [2];
  int         nsch;
  int         rst_on;
  logic       rdy_n1;

  bit         rx_en = 1'b0;
  int         rx_err = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_d;
  logic       rx_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dv(input logic v, input logic [7:0] b);
    dv[sel]  = v;
    byt[sel] = b;
  endtask

  // Offer a byte while idle, then walk to the first start-bit cycle (offset 0).
  task automatic start_byte(input string tag, input logic [7:0] b);
    int t;
    set_dv(1'b1, b);
    @(negedge clk);
    set_dv(1'b0, 8'h00);
    rdy_n1 = m_rdy;
    t = 0;
    while (m_ser !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_fall_latency"}, t, 1);
  endtask

  task automatic observe(input int n);
    for (int off = 0; off < n; off++) begin
      ser_log[off]  = m_ser;
      rdy_log[off]  = m_rdy;
      act_log[off]  = m_act;
      done_log[off] = m_done;
      par_log[off]  = m_par;
      for (int k = 0; k < nsch; k++) begin
        if (off == sch_off[k])     set_dv(1'b1, sch_byte[k]);
        if (off == sch_off[k] + 1) set_dv(1'b0, 8'h00);
      end
      if (off == rst_on)     rst = 1'b1;
      if (off == rst_on + 1) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [11:0] frame(input int start, input int nbits);
    logic [11:0] f;
    f = '0;
    for (int j = 0; j < nbits; j++) f[j] = ser_log[start + 43 + 87 * j];
    return f;
  endfunction

  function automatic int count_done(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (done_log[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_ser(input int a, input int b, input logic v);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (ser_log[i] === v) c++;
    return c;
  endfunction

  function automatic int first_inactive(input int n);
    for (int i = 0; i < n; i++) if (act_log[i] !== 1'b1) return i;
    return -1;
  endfunction

  // Reference receiver on the even/1-stop instance, enabled only for loopback.
  always begin
    @(negedge clk);
    if (rx_en && if_e.o_Tx_Serial === 1'b0) begin
      repeat (43) @(negedge clk);
      if (if_e.o_Tx_Serial !== 1'b0) rx_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (87) @(negedge clk);
        rx_d[b] = if_e.o_Tx_Serial;
      end
      repeat (87) @(negedge clk);
      rx_p = if_e.o_Tx_Serial;
      if (rx_p !== ^rx_d) rx_err++;
      repeat (87) @(negedge clk);
      if (if_e.o_Tx_Serial !== 1'b1) rx_err++;
      rx_q.push_back(rx_d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] b;
    sel    = 0;
    nsch   = 0;
    rst_on = -100;
    for (int i = 0; i < 3; i++) begin dv[i] = 1'b0; byt[i] = 8'h00; end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_serial", m_ser, 1);
    chk("rst_ready",  m_rdy, 1);
    chk("rst_active", m_act, 0);
    chk("rst_done",   m_done, 0);
    chk("rst_parity", m_par, 0);

    // Reset and DV on the same edge: byte must not be taken
    set_dv(1'b1, 8'hE7);
    @(negedge clk);
    chk("rst_dv_ready", m_rdy, 1);
    rst = 1'b0;
    set_dv(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("rst_dv_noframe", {m_ser, m_rdy, m_act}, 3'b110);

    // 0x2F even, 1 stop
    start_byte("b2f", 8'h2F);
    chk("b2f_ready_low", rdy_n1, 0);
    chk("b2f_ready_back", m_rdy, 1);
    observe(960);
    chk("b2f_frame", frame(0, 11), {1'b0, 1'b1, 1'b1, 8'h2F, 1'b0});
    chk("b2f_done_at_956", done_log[956], 1);
    chk("b2f_done_count", count_done(0, 959), 1);
    chk("b2f_parity", par_log[959], 1);
    chk("b2f_idle_after", {ser_log[957], act_log[957], act_log[956]}, 3'b101);

    // 0x00 even, 0xFF even
    start_byte("b00e", 8'h00);
    observe(960);
    chk("b00e_frame", frame(0, 11), {1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    chk("b00e_parity", par_log[959], 0);
    start_byte("bffe", 8'hFF);
    observe(960);
    chk("bffe_frame", frame(0, 11), {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0});
    chk("bffe_parity", par_log[959], 0);

    // 0x00 odd
    sel = 1;
    start_byte("b00o", 8'h00);
    observe(960);
    chk("b00o_frame", frame(0, 11), {1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
    chk("b00o_parity", par_log[959], 1);
    chk("b00o_done_count", count_done(0, 959), 1);

    // Back-to-back 0x55 then 0xA3; third DV (0x11) while not ready is dropped
    sel = 0;
    start_byte("b2b", 8'h55);
    nsch = 2;
    sch_off[0] = 99;  sch_byte[0] = 8'hA3;
    sch_off[1] = 200; sch_byte[1] = 8'h11;
    observe(2400);
    nsch = 0;
    chk("b2b_accept_ready", rdy_log[100], 0);
    chk("b2b_third_ignored_ready", rdy_log[201], 0);
    chk("b2b_ready_after_drain", rdy_log[957], 1);
    chk("b2b_frame1", frame(0, 11), {1'b0, 1'b1, 1'b0, 8'h55, 1'b0});
    chk("b2b_frame2", frame(957, 11), {1'b0, 1'b1, 1'b0, 8'hA3, 1'b0});
    chk("b2b_done1", done_log[956], 1);
    chk("b2b_done2", done_log[1913], 1);
    chk("b2b_done_count", count_done(0, 2399), 2);
    chk("b2b_active_len", first_inactive(2400), 1914);
    chk("b2b_no_third_frame", count_ser(1914, 2399, 1'b0), 0);

    // Reset in the 4th data bit of 0xC3 with 0x5A queued
    start_byte("rmid", 8'hC3);
    nsch = 1;
    sch_off[0] = 10; sch_byte[0] = 8'h5A;
    rst_on = 390;
    observe(2000);
    nsch = 0;
    rst_on = -100;
    chk("rmid_queued", rdy_log[11], 0);
    chk("rmid_bit3_low", {ser_log[390], act_log[390]}, 2'b01);
    chk("rmid_line_high", ser_log[391], 1);
    chk("rmid_ready", rdy_log[391], 1);
    chk("rmid_inactive", act_log[391], 0);
    chk("rmid_no_done", count_done(0, 1999), 0);
    chk("rmid_no_later_frame", count_ser(391, 1999, 1'b0), 0);

    // Two stop bits: 0x81 then queued 0x3C
    sel = 2;
    start_byte("s2", 8'h81);
    nsch = 1;
    sch_off[0] = 5; sch_byte[0] = 8'h3C;
    observe(2200);
    nsch = 0;
    chk("s2_frame1", frame(0, 12), {1'b1, 1'b1, 1'b0, 8'h81, 1'b0});
    chk("s2_stop_high_174", count_ser(870, 1043, 1'b1), 174);
    chk("s2_next_start_1044", {ser_log[1043], ser_log[1044]}, 2'b10);
    chk("s2_done1", done_log[1043], 1);
    chk("s2_done1_count", count_done(0, 1043), 1);
    chk("s2_frame2", frame(1044, 12), {1'b1, 1'b1, 1'b0, 8'h3C, 1'b0});
    chk("s2_done2", done_log[2087], 1);
    chk("s2_active_len", first_inactive(2200), 2088);

    // Loopback of 16 random bytes into the reference receiver
    sel   = 0;
    rx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      t = 0;
      while (m_rdy !== 1'b1 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("lb_ready", m_rdy, 1);
      set_dv(1'b1, b);
      @(negedge clk);
      set_dv(1'b0, 8'h00);
    end
    t = 0;
    while (rx_q.size() < 16 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("lb_count", rx_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_q.size()) chk("lb_byte", rx_q[i], exp_q[i]);
    end
    chk("lb_rx_errors", rx_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
